// File: rtl/tank_pkg.sv
// Shared constants and types for the mixing-tank plant and its controller bench.
// Keeping them here lets both sides agree on widths, thresholds and rates.
package tank_pkg;

  localparam int LW             = 16;
  localparam int DEF_CAPACITY   = 1000;
  localparam int DEF_L_THRESH   = 300;
  localparam int DEF_H_THRESH   = 900;
  localparam int DEF_FILL_RATE  = 2;
  localparam int DEF_DRAIN_RATE = 3;
  localparam int DEF_TICK_DIV   = 4;
  localparam int DEF_INIT_LEVEL = 0;

  typedef logic [LW-1:0] level_t;

  typedef struct packed {
    logic pump_1;
    logic pump_2;
    logic valve;
    logic mixer;
  } cmd_t;

endpackage

// File: rtl/tank_plant_if.sv
// Actuator commands and sensor/status lines between the tank controller (master)
// and the tank plant model (slave).
interface tank_plant_if;
  import tank_pkg::*;

  logic       pump_1;
  logic       pump_2;
  logic       valve;
  logic       mixer;
  logic       l_level;
  logic       h_level;
  level_t     level;
  logic       overflow;
  logic       dry_mix;
  logic       pump_mismatch;
  logic       fault;
  logic [7:0] batch_count;

  modport master (
    output pump_1, pump_2, valve, mixer,
    input  l_level, h_level, level, overflow, dry_mix, pump_mismatch, fault, batch_count
  );

  modport slave (
    input  pump_1, pump_2, valve, mixer,
    output l_level, h_level, level, overflow, dry_mix, pump_mismatch, fault, batch_count
  );

endinterface

// File: rtl/tank_tick_div.sv
// Process-tick prescaler: counts 0..TICK_DIV-1 and pulses o_tick on the last count.
// With TICK_DIV=1 the counter is pinned at 0 and o_tick is high every clock.
module tank_tick_div #(
  parameter int TICK_DIV = 4
) (
  input  logic clk,
  input  logic rst_n,
  output logic o_tick
);

  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] r_cnt;

  assign o_tick = (r_cnt == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      r_cnt <= '0;
    else if (o_tick) r_cnt <= '0;
    else             r_cnt <= r_cnt + 1'b1;
  end

endmodule

// File: rtl/tank_plant.sv
// Cycle-based mixing-tank plant: integrates fill level from pump/valve commands,
// drives registered level sensors, and tracks sticky safety flags and completed batches.
module tank_plant import tank_pkg::*; #(
  parameter int CAPACITY   = DEF_CAPACITY,
  parameter int L_THRESH   = DEF_L_THRESH,
  parameter int H_THRESH   = DEF_H_THRESH,
  parameter int FILL_RATE  = DEF_FILL_RATE,
  parameter int DRAIN_RATE = DEF_DRAIN_RATE,
  parameter int TICK_DIV   = DEF_TICK_DIV,
  parameter int INIT_LEVEL = DEF_INIT_LEVEL
) (
  input  logic       clk,
  input  logic       rst_n,
  tank_plant_if.slave bus
);

  localparam int SW = LW + 2;
  localparam logic signed [SW-1:0] S_FILL  = SW'(FILL_RATE);
  localparam logic signed [SW-1:0] S_DRAIN = SW'(DRAIN_RATE);
  localparam logic signed [SW-1:0] S_CAP   = SW'(CAPACITY);
  localparam level_t CAP_L  = LW'(CAPACITY);
  localparam level_t L_TH   = LW'(L_THRESH);
  localparam level_t H_TH   = LW'(H_THRESH);
  localparam level_t INIT_L = LW'(INIT_LEVEL);

  logic                 w_tick;
  cmd_t                 w_cmd;
  logic signed [SW-1:0] w_in;
  logic signed [SW-1:0] w_out;
  logic signed [SW-1:0] w_next;
  logic                 w_valve_fall;

  level_t     r_level;
  logic       r_l_level;
  logic       r_h_level;
  logic       r_overflow;
  logic       r_dry_mix;
  logic       r_mismatch;
  logic       r_skew;
  logic       r_seen_mix;
  logic       r_valve_d;
  logic [7:0] r_batch;

  tank_tick_div #(.TICK_DIV(TICK_DIV)) u_tick_div (
    .clk    (clk),
    .rst_n  (rst_n),
    .o_tick (w_tick)
  );

  assign w_cmd        = {bus.pump_1, bus.pump_2, bus.valve, bus.mixer};
  assign w_valve_fall = r_valve_d & ~w_cmd.valve;

  // Two extra bits give headroom above CAPACITY and a sign for drain below zero.
  always_comb begin
    w_in  = '0;
    w_out = '0;
    if (w_cmd.pump_1) w_in = w_in + S_FILL;
    if (w_cmd.pump_2) w_in = w_in + S_FILL;
    if (w_cmd.valve)  w_out = S_DRAIN;
    w_next = $signed({2'b00, r_level}) + w_in - w_out;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_level    <= INIT_L;
      r_overflow <= 1'b0;
    end else if (w_tick) begin
      if (w_next > S_CAP) begin
        r_level    <= CAP_L;
        r_overflow <= 1'b1;
      end else if (w_next[SW-1]) begin
        r_level    <= '0;
      end else begin
        r_level    <= w_next[LW-1:0];
      end
    end
  end

  // Sensors lag the level register by one clock, as a real probe would.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_l_level <= (INIT_L >= L_TH);
      r_h_level <= (INIT_L >= H_TH);
    end else begin
      r_l_level <= (r_level >= L_TH);
      r_h_level <= (r_level >= H_TH);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_dry_mix  <= 1'b0;
      r_mismatch <= 1'b0;
      r_skew     <= 1'b0;
    end else begin
      if (w_cmd.mixer && !r_h_level) r_dry_mix <= 1'b1;
      if (w_cmd.pump_1 != w_cmd.pump_2) begin
        if (r_skew) r_mismatch <= 1'b1;
        r_skew <= 1'b1;
      end else begin
        r_skew <= 1'b0;
      end
    end
  end

  // A batch counts only once the tank was mixed while full and then drained.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valve_d  <= 1'b0;
      r_seen_mix <= 1'b0;
      r_batch    <= 8'd0;
    end else begin
      r_valve_d <= w_cmd.valve;
      if (w_valve_fall && r_seen_mix) begin
        r_batch    <= r_batch + 8'd1;
        r_seen_mix <= 1'b0;
      end else if (w_cmd.mixer && r_h_level) begin
        r_seen_mix <= 1'b1;
      end
    end
  end

  assign bus.level         = r_level;
  assign bus.l_level       = r_l_level;
  assign bus.h_level       = r_h_level;
  assign bus.overflow      = r_overflow;
  assign bus.dry_mix       = r_dry_mix;
  assign bus.pump_mismatch = r_mismatch;
  assign bus.fault         = r_overflow | r_dry_mix | r_mismatch;
  assign bus.batch_count   = r_batch;

endmodule
